// File: rtl/feed_scheduler.sv
// feed_scheduler
//   Drives the dispenser servo from the register-file schedule. Three alarm
//   slots (hour/min/ampm) are compared against the live clock every cycle.
//   A manual request is also accepted. When a feed is granted, the servo
//   opens for `duration` seconds and then stays closed for a settle interval.
//
// Ports
//   clock          system clock
//   ctrl_reset_n   asynchronous active-low reset
//   sched_en       enables slot matching and the running feed (0 aborts it)
//   sec_tick       one-cycle pulse once per second
//   cur_hour/min   live time (hour 1..12, min 0..59)
//   cur_ampm       live AM(0)/PM(1)
//   slot_hour      {hour3,hour2,hour1}
//   slot_min       {min3,min2,min1}
//   slot_ampm      {ampm3,ampm2,ampm1}
//   duration       feed length in seconds (0 selects DEFAULT_DUR)
//   manual_req     level input; a rising edge requests a feed
//   pwm_open       servo open
//   busy           scheduler not idle
//   active_slot    one-hot slot being served (000 for manual or idle)
//   manual_active  the current feed is manual
//   feed_done      one-cycle pulse on normal feed completion
//   feed_count     completed feeds, saturating at 255
module feed_scheduler #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int DEFAULT_DUR   = 3,
  parameter int DUR_W         = 16
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             sched_en,
  input  logic             sec_tick,
  input  logic [7:0]       cur_hour,
  input  logic [7:0]       cur_min,
  input  logic             cur_ampm,
  input  logic [23:0]      slot_hour,
  input  logic [23:0]      slot_min,
  input  logic [2:0]       slot_ampm,
  input  logic [DUR_W-1:0] duration,
  input  logic             manual_req,
  output logic             pwm_open,
  output logic             busy,
  output logic [2:0]       active_slot,
  output logic             manual_active,
  output logic             feed_done,
  output logic [7:0]       feed_count
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [DUR_W-1:0] DEFAULT_LOAD = DUR_W'(DEFAULT_DUR);
  localparam logic [DUR_W-1:0] DUR_ONE      = DUR_W'(1);

  typedef enum logic [1:0] {IDLE, OPEN, SETTLE} state_t;

  state_t state, state_nxt;

  logic [2:0]       slot_valid;
  logic [2:0]       slot_match;
  logic [2:0]       slot_grant;
  logic [2:0]       served, served_nxt;
  logic             manual_q;
  logic             manual_rise;
  logic             manual_pend, manual_pend_nxt;
  logic             manual_grant;
  logic             start;
  logic             abort;
  logic             last_tick;
  logic [DUR_W-1:0] dur_cnt, dur_cnt_nxt;
  logic [SET_W-1:0] settle_cnt, settle_cnt_nxt;
  logic             pwm_open_nxt;
  logic [2:0]       active_slot_nxt;
  logic             manual_active_nxt;
  logic             feed_done_nxt;
  logic [7:0]       feed_count_nxt;

  // Slot decode: a slot only competes when it is programmed with a legal
  // time, equals the live time, and has not already fired this minute.
  always_comb begin
    slot_valid = '0;
    slot_match = '0;
    for (int i = 0; i < 3; i++) begin
      slot_valid[i] = (slot_hour[8*i +: 8] >= 8'd1) &&
                      (slot_hour[8*i +: 8] <= 8'd12) &&
                      (slot_min[8*i +: 8] <= 8'd59);
      slot_match[i] = sched_en && slot_valid[i] && !served[i] &&
                      (cur_hour == slot_hour[8*i +: 8]) &&
                      (cur_min == slot_min[8*i +: 8]) &&
                      (cur_ampm == slot_ampm[i]);
    end
  end

  // Fixed-priority arbitration: slot1 > slot2 > slot3 > manual. A manual
  // feed is only granted while scheduling is enabled, otherwise it would be
  // aborted on the very next edge and waste the pending request.
  always_comb begin
    slot_grant = 3'b000;
    if (slot_match[0])      slot_grant = 3'b001;
    else if (slot_match[1]) slot_grant = 3'b010;
    else if (slot_match[2]) slot_grant = 3'b100;
    manual_rise  = manual_req && !manual_q;
    manual_grant = manual_pend && sched_en && (slot_match == 3'b000);
    start        = (state == IDLE) && ((slot_match != 3'b000) || manual_grant);
    abort        = (state == OPEN) && !sched_en;
    last_tick    = (state == OPEN) && sched_en && sec_tick && (dur_cnt == DUR_ONE);
  end

  // Served flags stick until the minute moves off the slot's minute, so a
  // slot fires at most once per matching minute. The manual request is a
  // single-depth flag: extra edges while pending simply re-set it.
  always_comb begin
    served_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      served_nxt[i] = (start && slot_grant[i]) ||
                      (served[i] && (cur_min == slot_min[8*i +: 8]));
    end
    manual_pend_nxt = (start && manual_grant) ? 1'b0 : (manual_pend || manual_rise);
  end

  // State register.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  // Next-state logic. An abort and the final tick both leave OPEN through
  // SETTLE; only the final tick counts as a completed feed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = OPEN;
      OPEN:    if (abort || last_tick) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values. The duration is latched at start so
  // later register writes do not stretch or cut the running feed. A tick on
  // the start edge is ignored because the load takes precedence.
  always_comb begin
    pwm_open_nxt      = pwm_open;
    active_slot_nxt   = active_slot;
    manual_active_nxt = manual_active;
    feed_done_nxt     = 1'b0;
    feed_count_nxt    = feed_count;
    dur_cnt_nxt       = dur_cnt;
    settle_cnt_nxt    = settle_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          dur_cnt_nxt       = (duration == '0) ? DEFAULT_LOAD : duration;
          pwm_open_nxt      = 1'b1;
          active_slot_nxt   = slot_grant;
          manual_active_nxt = (slot_grant == 3'b000);
        end
      end
      OPEN: begin
        if (abort || last_tick) begin
          pwm_open_nxt      = 1'b0;
          active_slot_nxt   = 3'b000;
          manual_active_nxt = 1'b0;
          settle_cnt_nxt    = SETTLE_LAST;
          feed_done_nxt     = last_tick;
          if (last_tick && (feed_count != 8'hFF)) feed_count_nxt = feed_count + 8'd1;
        end else if (sec_tick) begin
          dur_cnt_nxt = dur_cnt - DUR_ONE;
        end
      end
      SETTLE: begin
        if (settle_cnt != '0) settle_cnt_nxt = settle_cnt - SET_W'(1);
      end
      default: ;
    endcase
  end

  // Registered outputs and internal counters. Reset is asynchronous so the
  // servo closes immediately even mid-feed.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      pwm_open      <= 1'b0;
      active_slot   <= 3'b000;
      manual_active <= 1'b0;
      feed_done     <= 1'b0;
      feed_count    <= 8'd0;
      dur_cnt       <= '0;
      settle_cnt    <= '0;
      served        <= 3'b000;
      manual_q      <= 1'b0;
      manual_pend   <= 1'b0;
    end else begin
      pwm_open      <= pwm_open_nxt;
      active_slot   <= active_slot_nxt;
      manual_active <= manual_active_nxt;
      feed_done     <= feed_done_nxt;
      feed_count    <= feed_count_nxt;
      dur_cnt       <= dur_cnt_nxt;
      settle_cnt    <= settle_cnt_nxt;
      served        <= served_nxt;
      manual_q      <= manual_req;
      manual_pend   <= manual_pend_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_feed_scheduler.sv
// tb_feed_scheduler
//   Self-checking bench for feed_scheduler. A behavioural model tracks the
//   remaining open seconds, remaining rest cycles and who is being fed, and
//   its outputs are compared with the DUT on every falling clock edge.
//   Directed sequences cover slot feeds, arbitration, manual requests,
//   default duration, abort, count saturation, missed minutes and reset.
module tb_feed_scheduler;

  localparam int SETTLE = 10;
  localparam int DEF    = 3;
  localparam int DW     = 16;
  localparam int TICK_P = 20;

  logic          clock        = 1'b0;
  logic          ctrl_reset_n = 1'b1;
  logic          sched_en     = 1'b0;
  logic          sec_tick     = 1'b0;
  logic [7:0]    cur_hour     = 8'd0;
  logic [7:0]    cur_min      = 8'd0;
  logic          cur_ampm     = 1'b0;
  logic [23:0]   slot_hour    = 24'd0;
  logic [23:0]   slot_min     = 24'd0;
  logic [2:0]    slot_ampm    = 3'd0;
  logic [DW-1:0] duration     = '0;
  logic          manual_req   = 1'b0;
  logic          pwm_open;
  logic          busy;
  logic [2:0]    active_slot;
  logic          manual_active;
  logic          feed_done;
  logic [7:0]    feed_count;

  int errors = 0;
  int checks = 0;

  feed_scheduler #(
    .SETTLE_CYCLES(SETTLE),
    .DEFAULT_DUR  (DEF),
    .DUR_W        (DW)
  ) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .sched_en     (sched_en),
    .sec_tick     (sec_tick),
    .cur_hour     (cur_hour),
    .cur_min      (cur_min),
    .cur_ampm     (cur_ampm),
    .slot_hour    (slot_hour),
    .slot_min     (slot_min),
    .slot_ampm    (slot_ampm),
    .duration     (duration),
    .manual_req   (manual_req),
    .pwm_open     (pwm_open),
    .busy         (busy),
    .active_slot  (active_slot),
    .manual_active(manual_active),
    .feed_done    (feed_done),
    .feed_count   (feed_count)
  );

  always #5 clock = ~clock;

  // Behavioural model: m_left = open seconds left, m_rest = rest cycles
  // left, m_who = 0 none, 1..3 slot number, 4 manual.
  int       m_left = 0;
  int       m_rest = 0;
  int       m_who  = 0;
  int       m_count = 0;
  logic     m_done = 1'b0;
  logic [2:0] m_served = 3'b000;
  logic     m_pend = 1'b0;
  logic     m_prev = 1'b0;

  function automatic bit slot_wants(input int i);
    logic [7:0] h;
    logic [7:0] m;
    h = slot_hour[8*i +: 8];
    m = slot_min[8*i +: 8];
    return sched_en && (h >= 8'd1) && (h <= 8'd12) && (m <= 8'd59) &&
           (h == cur_hour) && (m == cur_min) && (slot_ampm[i] == cur_ampm) &&
           !m_served[i];
  endfunction

  // Model update on each edge, using the inputs held stable since the
  // previous falling edge.
  always @(posedge clock or negedge ctrl_reset_n) begin : model_blk
    int   pick;
    int   ln;
    int   rn;
    int   wn;
    int   cn;
    logic dn;
    if (!ctrl_reset_n) begin
      m_left   <= 0;
      m_rest   <= 0;
      m_who    <= 0;
      m_count  <= 0;
      m_done   <= 1'b0;
      m_served <= 3'b000;
      m_pend   <= 1'b0;
      m_prev   <= 1'b0;
    end else begin
      pick = 0;
      if (m_left == 0 && m_rest == 0) begin
        for (int i = 2; i >= 0; i--) if (slot_wants(i)) pick = i + 1;
        if (pick == 0 && m_pend && sched_en) pick = 4;
      end
      for (int i = 0; i < 3; i++) begin
        if (pick == i + 1)                       m_served[i] <= 1'b1;
        else if (cur_min != slot_min[8*i +: 8])  m_served[i] <= 1'b0;
      end
      if (pick == 4)                      m_pend <= 1'b0;
      else if (manual_req && !m_prev)     m_pend <= 1'b1;
      m_prev <= manual_req;
      ln = m_left;
      rn = m_rest;
      wn = m_who;
      cn = m_count;
      dn = 1'b0;
      if (pick != 0) begin
        ln = (duration == 0) ? DEF : int'(duration);
        wn = pick;
      end else if (m_left > 0) begin
        if (!sched_en) begin
          ln = 0;
          rn = SETTLE;
          wn = 0;
        end else if (sec_tick) begin
          ln = m_left - 1;
          if (ln == 0) begin
            dn = 1'b1;
            cn = (m_count < 255) ? m_count + 1 : 255;
            rn = SETTLE;
            wn = 0;
          end
        end
      end else if (m_rest > 0) begin
        rn = m_rest - 1;
      end
      m_left  <= ln;
      m_rest  <= rn;
      m_who   <= wn;
      m_count <= cn;
      m_done  <= dn;
    end
  end

  function automatic logic [14:0] model_outputs();
    logic [2:0] s;
    s = 3'b000;
    if (m_who >= 1 && m_who <= 3) s = 3'(1 << (m_who - 1));
    return {(m_left > 0), (m_left > 0) || (m_rest > 0), s, (m_who == 4), m_done, 8'(m_count)};
  endfunction

  // Observation helpers: start log (code: 1/2/4 slot, 8 manual), feed_done
  // pulses, and sec_tick events seen while the servo was open.
  int   start_log[$];
  int   done_total = 0;
  logic pwm_prev = 1'b0;
  int   cur_ticks = 0;
  int   last_ticks = 0;

  always @(negedge clock) begin
    pwm_prev <= pwm_open;
    if (pwm_open && !pwm_prev) start_log.push_back(int'({manual_active, active_slot}));
    if (feed_done) done_total <= done_total + 1;
  end

  always @(posedge clock) begin
    if (pwm_open) begin
      if (sec_tick) cur_ticks <= cur_ticks + 1;
    end else if (cur_ticks != 0) begin
      last_ticks <= cur_ticks;
      cur_ticks  <= 0;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic compare_loop();
    logic [14:0] dut_vec;
    logic [14:0] exp_vec;
    forever begin
      @(negedge clock);
      dut_vec = {pwm_open, busy, active_slot, manual_active, feed_done, feed_count};
      exp_vec = model_outputs();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL cycle_compare: got %h, expected %h (t=%0t)", dut_vec, exp_vec, $time);
      end
    end
  endtask

  task automatic tick_gen();
    forever begin
      repeat (TICK_P - 1) @(negedge clock);
      sec_tick = 1'b1;
      @(negedge clock);
      sec_tick = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] h, input logic [7:0] m, input logic pm);
    @(negedge clock);
    cur_hour = h;
    cur_min  = m;
    cur_ampm = pm;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_busy(input int budget);
    int n;
    n = 0;
    while (!busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_output("wait_busy", int'(busy), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_output("wait_idle", int'(busy), 0);
  endtask

  task automatic manual_pulse();
    @(negedge clock);
    manual_req = 1'b1;
    @(negedge clock);
    manual_req = 1'b0;
  endtask

  task automatic manual_feed();
    manual_pulse();
    wait_busy(10);
    wait_idle(300);
  endtask

  initial begin
    int size0;
    int done0;
    int n;
    fork
      compare_loop();
      tick_gen();
    join_none
    #1 ctrl_reset_n = 1'b0;
    wait_cycles(3);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_count", int'(feed_count), 0);
    ctrl_reset_n = 1'b1;
    sched_en     = 1'b1;
    wait_cycles(2);
    check_output("idle_after_release", int'(busy), 0);

    // Slot feed: slot1 = 7:30 PM, two seconds.
    $display("[TB] slot feed");
    duration  = 16'd2;
    slot_hour = {8'd0, 8'd0, 8'd7};
    slot_min  = {8'd0, 8'd0, 8'd30};
    slot_ampm = 3'b001;
    apply_stimulus(8'd7, 8'd30, 1'b1);
    @(negedge clock);
    check_output("slot_open_latency", int'(pwm_open), 1);
    check_output("slot_active", int'(active_slot), 1);
    wait_idle(300);
    check_output("slot_ticks_open", last_ticks, 2);
    check_output("slot_done_pulses", done_total, 1);
    check_output("slot_count", int'(feed_count), 1);
    wait_cycles(60);
    check_output("no_refire_count", int'(feed_count), 1);
    check_output("no_refire_starts", start_log.size(), 1);
    apply_stimulus(8'd7, 8'd31, 1'b1);

    // Arbitration: slot1 and slot3 both at 8:00 AM.
    $display("[TB] arbitration");
    duration  = 16'd1;
    slot_hour = {8'd8, 8'd0, 8'd8};
    slot_min  = 24'd0;
    slot_ampm = 3'b000;
    apply_stimulus(8'd8, 8'd0, 1'b0);
    wait_busy(10);
    wait_idle(300);
    wait_busy(10);
    wait_idle(300);
    check_output("arb_count", int'(feed_count), 3);
    check_output("arb_first", start_log[1], 1);
    check_output("arb_second", start_log[2], 4);
    apply_stimulus(8'd8, 8'd1, 1'b0);
    slot_hour = {8'd8, 8'd0, 8'd0};
    apply_stimulus(8'd8, 8'd0, 1'b0);
    wait_busy(10);
    wait_idle(300);
    wait_cycles(30);
    check_output("unprogrammed_starts", start_log.size(), 4);
    check_output("unprogrammed_slot", start_log[3], 4);
    check_output("unprogrammed_count", int'(feed_count), 4);
    apply_stimulus(8'd8, 8'd2, 1'b0);

    // Manual edges during a slot2 feed; the second edge is dropped.
    $display("[TB] manual during feed");
    slot_hour = {8'd0, 8'd9, 8'd0};
    slot_min  = {8'd0, 8'd15, 8'd0};
    apply_stimulus(8'd9, 8'd15, 1'b0);
    wait_busy(10);
    wait_cycles(2);
    manual_req = 1'b1;
    wait_cycles(2);
    manual_req = 1'b0;
    wait_cycles(2);
    manual_req = 1'b1;
    wait_cycles(2);
    manual_req = 1'b0;
    wait_idle(300);
    wait_busy(10);
    wait_idle(300);
    wait_cycles(60);
    check_output("manual_count", int'(feed_count), 6);
    check_output("manual_starts", start_log.size(), 6);
    check_output("manual_first_slot2", start_log[4], 2);
    check_output("manual_follow", start_log[5], 8);
    apply_stimulus(8'd9, 8'd16, 1'b0);

    // Default duration, then abort after one second of a five-second feed.
    $display("[TB] default and abort");
    duration = 16'd0;
    manual_feed();
    check_output("default_ticks", last_ticks, 3);
    check_output("default_count", int'(feed_count), 7);
    duration = 16'd5;
    done0 = done_total;
    manual_pulse();
    wait_busy(10);
    n = 0;
    while (cur_ticks < 1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_output("abort_one_tick", cur_ticks, 1);
    sched_en = 1'b0;
    @(negedge clock);
    check_output("abort_closed", int'(pwm_open), 0);
    check_output("abort_settling", int'(busy), 1);
    wait_idle(300);
    sched_en = 1'b1;
    check_output("abort_no_done", done_total, done0);
    check_output("abort_count", int'(feed_count), 7);

    // Saturate the feed counter with manual feeds.
    $display("[TB] saturation");
    duration = 16'd1;
    for (int k = 0; k < 300 && feed_count != 8'd255; k++) manual_feed();
    check_output("count_reaches_255", int'(feed_count), 255);
    done0 = done_total;
    manual_feed();
    check_output("count_saturated", int'(feed_count), 255);
    check_output("saturated_done", done_total, done0 + 1);

    // A slot match that lives only while busy is never served.
    $display("[TB] missed minute");
    duration = 16'd2;
    size0 = start_log.size();
    manual_pulse();
    wait_busy(10);
    slot_hour = {8'd0, 8'd0, 8'd10};
    slot_min  = {8'd0, 8'd0, 8'd45};
    slot_ampm = 3'b000;
    apply_stimulus(8'd10, 8'd45, 1'b0);
    wait_cycles(5);
    apply_stimulus(8'd10, 8'd46, 1'b0);
    wait_idle(300);
    wait_cycles(30);
    check_output("missed_minute_starts", start_log.size(), size0 + 1);

    // Reset in the middle of an open feed.
    $display("[TB] reset mid-feed");
    duration = 16'd5;
    manual_pulse();
    wait_busy(10);
    wait_cycles(3);
    check_output("pre_reset_open", int'(pwm_open), 1);
    #2 ctrl_reset_n = 1'b0;
    #1;
    check_output("async_pwm_drop", int'(pwm_open), 0);
    check_output("async_count_clear", int'(feed_count), 0);
    check_output("async_busy_clear", int'(busy), 0);
    check_output("async_manual_clear", int'(manual_active), 0);
    wait_cycles(3);
    ctrl_reset_n = 1'b1;
    wait_cycles(2);
    check_output("post_reset_idle", int'(busy), 0);
    check_output("post_reset_pwm", int'(pwm_open), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
